// File: rtl/l2_config_and_types.sv
// ---------------------------------------------------------------------------
// l2_config_and_types
// Shared configuration constants and types for the L2 write path.
//   L2_NUM_PORTS / PORT_W      : number of requesting ports and port-id width
//   L2_MAX_BURST_BEATS         : longest burst (burst_size field is beats-1)
//   l2_data_attributes_t       : arbiter attributes entry {id, burst_size, abort}
//   l2_data_request_t          : per-port write-data entry {data, be}
//   l2_wr_seq_state_t          : write-data sequencer FSM states
// ---------------------------------------------------------------------------
package l2_config_and_types;

    localparam int L2_NUM_PORTS       = 2;
    localparam int PORT_W             = $clog2(L2_NUM_PORTS);
    localparam int L2_MAX_BURST_BEATS = 32;
    localparam int BURST_W            = $clog2(L2_MAX_BURST_BEATS);
    localparam int DATA_W             = 32;
    localparam int BE_W               = DATA_W / 8;

    typedef struct packed {
        logic [PORT_W-1:0]  id;
        logic [BURST_W-1:0] burst_size;  // beats - 1
        logic               abort;
    } l2_data_attributes_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } l2_data_request_t;

    typedef enum logic {
        L2_WR_SEQ_IDLE,
        L2_WR_SEQ_ACTIVE
    } l2_wr_seq_state_t;

endpackage

// File: rtl/l2_port_data_mux.sv
// ---------------------------------------------------------------------------
// l2_port_data_mux
// Selects the write-data FIFO head of the port owning the current burst and
// decodes the one-hot dequeue for that port.
//   i_cur_id          : port id of the burst in progress
//   i_port_data       : per-port FIFO heads
//   i_port_data_valid : per-port FIFO non-empty flags
//   i_fire            : a beat is consumed this cycle (sent or drained)
//   o_sel_data        : head of the selected port
//   o_sel_valid       : selected port has data
//   o_pop             : one-hot dequeue, only ever for i_cur_id
// ---------------------------------------------------------------------------
module l2_port_data_mux
    import l2_config_and_types::*;
(
    input  logic [PORT_W-1:0]                         i_cur_id,
    input  l2_data_request_t [L2_NUM_PORTS-1:0]       i_port_data,
    input  logic [L2_NUM_PORTS-1:0]                   i_port_data_valid,
    input  logic                                      i_fire,
    output l2_data_request_t                          o_sel_data,
    output logic                                      o_sel_valid,
    output logic [L2_NUM_PORTS-1:0]                   o_pop
);

    // Loop compare rather than a direct index so an id outside the port
    // range (non power-of-two port counts) selects nothing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        o_sel_data  = '0;
        o_sel_valid = 1'b0;
        o_pop       = '0;
        for (int i = 0; i < L2_NUM_PORTS; i++) begin
            if (i_cur_id == PORT_W'(i)) begin
                o_sel_data  = i_port_data[i];
                o_sel_valid = i_port_data_valid[i];
                o_pop[i]    = i_fire;
            end
        end
    end

endmodule

// File: rtl/l2_write_data_sequencer.sv
// ---------------------------------------------------------------------------
// l2_write_data_sequencer
// Memory-side stage after the L2 arbiter. Takes one attributes entry per
// write request and moves that request's beats from the owning port's data
// FIFO to the memory write channel (or discards them when the request was
// aborted), so write data reaches memory in request order.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   attr_valid/attr   : attributes FIFO head; attr_pop dequeues it
//   port_data_valid   : per-port data FIFO non-empty
//   port_data         : per-port data FIFO heads; port_data_pop dequeues
//   mem_wr_*          : write beat channel (valid/ready, data, be, last)
//   busy              : burst in progress
//
// Build option: define L2_WR_SEQ_BACK_TO_BACK_EN to pick up the next
// attributes entry on the final beat of a burst (no idle cycle between
// bursts). Without it one IDLE cycle always separates bursts.
// ---------------------------------------------------------------------------
module l2_write_data_sequencer
    import l2_config_and_types::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  attr_valid,
    input  l2_data_attributes_t                   attr,
    output logic                                  attr_pop,
    input  logic [L2_NUM_PORTS-1:0]               port_data_valid,
    input  l2_data_request_t [L2_NUM_PORTS-1:0]   port_data,
    output logic [L2_NUM_PORTS-1:0]               port_data_pop,
    output logic                                  mem_wr_valid,
    output logic [DATA_W-1:0]                     mem_wr_data,
    output logic [BE_W-1:0]                       mem_wr_be,
    output logic                                  mem_wr_last,
    input  logic                                  mem_wr_ready,
    output logic                                  busy
);

    l2_wr_seq_state_t    r_state;
    logic [BURST_W-1:0]  r_beat_cnt;   // beats remaining after the current one
    logic [PORT_W-1:0]   r_cur_id;
    logic                r_cur_abort;
    logic                r_init;       // low for the first cycle after reset

    logic                w_active;
    logic                w_sel_valid;
    l2_data_request_t    w_sel_data;
    logic                w_fire;
    logic                w_last_fire;

    assign w_active = (r_state == L2_WR_SEQ_ACTIVE);

    l2_port_data_mux u_port_data_mux (
        .i_cur_id          (r_cur_id),
        .i_port_data       (port_data),
        .i_port_data_valid (port_data_valid),
        .i_fire            (w_fire),
        .o_sel_data        (w_sel_data),
        .o_sel_valid       (w_sel_valid),
        .o_pop             (port_data_pop)
    );

    // Aborted bursts never present a beat; they drain as fast as data shows
    // up. Valid is a function of FIFO state only, never of mem_wr_ready.
    assign mem_wr_valid = w_active & ~r_cur_abort & w_sel_valid;
    assign w_fire       = w_active & w_sel_valid & (r_cur_abort | mem_wr_ready);
    assign w_last_fire  = w_fire & (r_beat_cnt == '0);

    assign mem_wr_data  = mem_wr_valid ? w_sel_data.data : '0;
    assign mem_wr_be    = mem_wr_valid ? w_sel_data.be   : '0;
    assign mem_wr_last  = mem_wr_valid & (r_beat_cnt == '0);
    assign busy         = w_active;

    // r_init keeps attr_pop quiet on the first cycle after reset release even
    // when the attributes FIFO already holds an entry.
`ifdef L2_WR_SEQ_BACK_TO_BACK_EN
    assign attr_pop = attr_valid & ((r_init & ~w_active) | w_last_fire);
`else
    assign attr_pop = attr_valid & r_init & ~w_active;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= L2_WR_SEQ_IDLE;
            r_beat_cnt  <= '0;
            r_cur_id    <= '0;
            r_cur_abort <= 1'b0;
            r_init      <= 1'b0;
        end else begin
            r_init <= 1'b1;
            case (r_state)
                L2_WR_SEQ_IDLE: begin
                    if (attr_pop) begin
                        r_cur_id    <= attr.id;
                        r_beat_cnt  <= attr.burst_size;
                        r_cur_abort <= attr.abort;
                        r_state     <= L2_WR_SEQ_ACTIVE;
                    end
                end
                L2_WR_SEQ_ACTIVE: begin
                    if (w_fire) begin
                        if (r_beat_cnt == '0) begin
                            // attr_pop can only be high here when back-to-back
                            // streaming is built in; otherwise drop to IDLE.
                            if (attr_pop) begin
                                r_cur_id    <= attr.id;
                                r_beat_cnt  <= attr.burst_size;
                                r_cur_abort <= attr.abort;
                            end else begin
                                r_state <= L2_WR_SEQ_IDLE;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= L2_WR_SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_write_data_sequencer.sv
// ---------------------------------------------------------------------------
// tb_l2_write_data_sequencer
// Directed bench: the attributes and per-port data FIFOs are modelled with
// queues; each issued burst pushes its expected beats into a scoreboard that
// an independent monitor pops whenever the memory channel accepts a beat.
// ---------------------------------------------------------------------------
module tb_l2_write_data_sequencer;
    import l2_config_and_types::*;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic                                 attr_valid;
    l2_data_attributes_t                  attr;
    logic                                 attr_pop;
    logic [L2_NUM_PORTS-1:0]              port_data_valid;
    l2_data_request_t [L2_NUM_PORTS-1:0]  port_data;
    logic [L2_NUM_PORTS-1:0]              port_data_pop;
    logic                                 mem_wr_valid;
    logic [DATA_W-1:0]                    mem_wr_data;
    logic [BE_W-1:0]                      mem_wr_be;
    logic                                 mem_wr_last;
    logic                                 mem_wr_ready;
    logic                                 busy;

    always #5 clk = ~clk;

    l2_write_data_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .attr_valid      (attr_valid),
        .attr            (attr),
        .attr_pop        (attr_pop),
        .port_data_valid (port_data_valid),
        .port_data       (port_data),
        .port_data_pop   (port_data_pop),
        .mem_wr_valid    (mem_wr_valid),
        .mem_wr_data     (mem_wr_data),
        .mem_wr_be       (mem_wr_be),
        .mem_wr_last     (mem_wr_last),
        .mem_wr_ready    (mem_wr_ready),
        .busy            (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
        int          port;
    } exp_t;

    exp_t                sb[$];
    l2_data_attributes_t attr_q[$];
    l2_data_request_t    dq0[$];
    l2_data_request_t    dq1[$];
    int                  beat_cyc[$];

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   n_beats = 0;

    // Per-window statistics gathered by tick()
    logic       ap;
    logic [1:0] dp;
    logic       vld;
    int         pop_cnt0, pop_cnt1, vld_cnt, first_pop, last_pop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_heads();
        attr_valid         = (attr_q.size() != 0);
        attr               = attr_valid ? attr_q[0] : '0;
        port_data_valid[0] = (dq0.size() != 0);
        port_data[0]       = port_data_valid[0] ? dq0[0] : '0;
        port_data_valid[1] = (dq1.size() != 0);
        port_data[1]       = port_data_valid[1] ? dq1[0] : '0;
    endtask

    task automatic clr_stats();
        pop_cnt0 = 0; pop_cnt1 = 0; vld_cnt = 0; first_pop = -1; last_pop = -1;
    endtask

    // One clock of the FIFO environment: sample requests mid-cycle, apply the
    // dequeues just after the edge and present the new heads.
    task automatic tick();
        @(negedge clk);
        ap  = attr_pop;
        dp  = port_data_pop;
        vld = mem_wr_valid;
        if (dp != 2'b00) check("pop_onehot", 64'($countones(dp)), 1);
        if (dp[0]) check("pop0_nonempty", 64'(dq0.size() != 0), 1);
        if (dp[1]) check("pop1_nonempty", 64'(dq1.size() != 0), 1);
        if (ap)    check("attr_pop_nonempty", 64'(attr_q.size() != 0), 1);
        if (vld)   check("valid_has_data", 64'((dq0.size() + dq1.size()) != 0), 1);
        if (vld) vld_cnt++;
        if (dp[0]) pop_cnt0++;
        if (dp[1]) pop_cnt1++;
        if (dp != 2'b00) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        if (ap && attr_q.size() != 0) void'(attr_q.pop_front());
        if (dp[0] && dq0.size() != 0) void'(dq0.pop_front());
        if (dp[1] && dq1.size() != 0) void'(dq1.pop_front());
        drive_heads();
    endtask

    task automatic push_word(input int port, input logic [31:0] d, input logic [3:0] be);
        l2_data_request_t w;
        w.data = d;
        w.be   = be;
        if (port == 0) dq0.push_back(w); else dq1.push_back(w);
    endtask

    // Queue one request: attributes entry, its data words and, unless
    // aborted, the beats memory must see.
    task automatic push_burst(input int port, input int n, input logic [31:0] base,
                              input logic [3:0] be, input bit abort, input bit with_data);
        l2_data_attributes_t a;
        exp_t e;
        a.id         = PORT_W'(port);
        a.burst_size = BURST_W'(n - 1);
        a.abort      = abort;
        attr_q.push_back(a);
        for (int i = 0; i < n; i++) begin
            if (with_data) push_word(port, base + 32'(i), be);
            if (!abort) begin
                e.data = base + 32'(i);
                e.be   = be;
                e.last = (i == n - 1);
                e.port = port;
                sb.push_back(e);
            end
        end
        drive_heads();
    endtask

    function automatic bit idle_all();
        return sb.size() == 0 && attr_q.size() == 0 && dq0.size() == 0 &&
               dq1.size() == 0 && !busy;
    endfunction

    task automatic run(input int budget, input string name, input bit toggle);
        int k = 0;
        while (!idle_all() && k < budget) begin
            if (toggle) mem_wr_ready = ~mem_wr_ready;
            tick();
            k++;
        end
        check({name, "_complete"}, 64'(k < budget), 1);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({attr_pop, port_data_pop, mem_wr_valid, mem_wr_data,
                    mem_wr_be, mem_wr_last, busy});
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every accepted beat against the scoreboard and checks
    // that a stalled beat holds valid and payload until accepted.
    initial begin
        exp_t        e;
        bit          hold_pending = 0;
        logic [35:0] hold_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", 64'(mem_wr_valid), 1);
                    check("hold_payload", 64'({mem_wr_data, mem_wr_be}), 64'(hold_val));
                end
                hold_pending = mem_wr_valid && !mem_wr_ready;
                hold_val     = {mem_wr_data, mem_wr_be};
                if (mem_wr_valid && mem_wr_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", mem_wr_data);
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", 64'(mem_wr_data), 64'(e.data));
                        check("beat_be",   64'(mem_wr_be),   64'(e.be));
                        check("beat_last", 64'(mem_wr_last), 64'(e.last));
                        check("beat_pop",  64'(port_data_pop), 64'(1) << e.port);
                        beat_cyc.push_back(cyc);
                        n_beats++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_beats;
        int bi;
        int k;

        // ---------------- reset, with the single-beat request preloaded
        rst          = 1'b1;
        mem_wr_ready = 1'b1;
        clr_stats();
        push_burst(1, 1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", all_outputs(), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("first_cycle_after_rst", all_outputs(), 0);

        // ---------------- single beat on port 1
        tick();
        check("single_attr_pop", 64'(ap), 1);
        base_beats = n_beats;
        run(10, "single", 1'b0);
        check("single_beats", 64'(n_beats - base_beats), 1);
        check("single_pop1", 64'(pop_cnt1), 1);

        // ---------------- 4-beat burst with toggling backpressure
        base_beats = n_beats;
        push_burst(0, 4, 32'h1000_0000, 4'hA, 1'b0, 1'b1);
        run(40, "backpressure", 1'b1);
        check("backpressure_beats", 64'(n_beats - base_beats), 4);
        mem_wr_ready = 1'b1;

        // ---------------- abort drain: 8 words on port 1, nothing to memory
        clr_stats();
        push_burst(1, 8, 32'hA0A0_0000, 4'hF, 1'b1, 1'b1);
        run(30, "abort", 1'b0);
        check("abort_valid_cycles", 64'(vld_cnt), 0);
        check("abort_pops_port1", 64'(pop_cnt1), 8);
        check("abort_pops_port0", 64'(pop_cnt0), 0);
        check("abort_pop_span", 64'(last_pop - first_pop), 7);

        // ---------------- underflow: port 0 words arrive two cycles apart
        clr_stats();
        base_beats = n_beats;
        push_burst(0, 3, 32'h7700_0000, 4'h6, 1'b0, 1'b0);
        push_word(0, 32'h7700_0000, 4'h6);
        drive_heads();
        k = 0;
        while (!idle_all() && k < 30) begin
            tick();
            if (k == 1) begin push_word(0, 32'h7700_0001, 4'h6); drive_heads(); end
            if (k == 3) begin push_word(0, 32'h7700_0002, 4'h6); drive_heads(); end
            k++;
        end
        check("underflow_complete", 64'(k < 30), 1);
        check("underflow_beats", 64'(n_beats - base_beats), 3);
        check("underflow_pops", 64'(pop_cnt0), 3);

        // ---------------- ordering across ports
        bi = beat_cyc.size();
        push_burst(0, 2, 32'h2000_0000, 4'hF, 1'b0, 1'b1);
        push_burst(1, 1, 32'h3000_0000, 4'h3, 1'b0, 1'b1);
        push_burst(0, 1, 32'h4000_0000, 4'hC, 1'b0, 1'b1);
        run(30, "ordering", 1'b0);
        check("ordering_beats", 64'(beat_cyc.size() - bi), 4);
        if (beat_cyc.size() - bi == 4) begin
            check("ordering_gap_in_burst", 64'(beat_cyc[bi+1] - beat_cyc[bi]), 1);
`ifdef L2_WR_SEQ_BACK_TO_BACK_EN
            check("ordering_gap_b1_b2", 64'(beat_cyc[bi+2] - beat_cyc[bi+1]), 1);
            check("ordering_gap_b2_b3", 64'(beat_cyc[bi+3] - beat_cyc[bi+2]), 1);
`else
            check("ordering_gap_b1_b2", 64'(beat_cyc[bi+2] - beat_cyc[bi+1]), 2);
            check("ordering_gap_b2_b3", 64'(beat_cyc[bi+3] - beat_cyc[bi+2]), 2);
`endif
        end

        // ---------------- reset after beat 2 of 5
        base_beats = n_beats;
        push_burst(0, 5, 32'h5000_0000, 4'hF, 1'b0, 1'b1);
        k = 0;
        while (n_beats < base_beats + 2 && k < 20) begin
            tick();
            k++;
        end
        check("midrst_two_beats", 64'(n_beats - base_beats), 2);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", all_outputs(), 0);
        sb.delete();
        attr_q.delete();
        dq0.delete();
        dq1.delete();
        drive_heads();
        @(posedge clk);
        #2 rst = 1'b0;
        base_beats = n_beats;
        push_burst(1, 1, 32'h6000_0006, 4'h5, 1'b0, 1'b1);
        run(10, "post_rst", 1'b0);
        check("post_rst_beats", 64'(n_beats - base_beats), 1);
        check("post_rst_busy", 64'(busy), 0);

        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
